// File: rtl/ps2_event_rx.sv
// rtl/ps2_event_rx.sv - PS/2 frame receiver with E0/F0 prefix decoding and key-event FIFO
// Optional macro PS2_PARITY_CHECK_EN: enables odd-parity checking; otherwise parity_err is tied to 0.
module ps2_event_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          ev_ready,
    input  logic                          clear_ovf,
    output logic                          ev_valid,
    output logic [9:0]                    ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RX    = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and clock filter
    // ------------------------------------------------------------------
    logic                  ps2c_meta_q, ps2c_meta_d;
    logic                  ps2c_sync_q, ps2c_sync_d;
    logic                  ps2d_meta_q, ps2d_meta_d;
    logic                  ps2d_sync_q, ps2d_sync_d;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_q, filt_d;
    logic                  fall_q, fall_d;

    // Next-state for the synchronisers, the sample window and the edge pulse
    always_comb begin
        ps2c_meta_d = ps2c;
        ps2c_sync_d = ps2c_meta_q;
        ps2d_meta_d = ps2d;
        ps2d_sync_d = ps2d_meta_q;
        filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], ps2c_sync_q};
        if (&filt_sr_q) begin
            filt_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
        fall_d = filt_q & ~filt_d;
    end

    // Line sampling registers; idle-high reset values so no edge appears after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
            filt_sr_q   <= {FILTER_LEN{1'b1}};
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            ps2c_meta_q <= ps2c_meta_d;
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_meta_q <= ps2d_meta_d;
            ps2d_sync_q <= ps2d_sync_d;
            filt_sr_q   <= filt_sr_d;
            filt_q      <= filt_d;
            fall_q      <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and prefix decoder
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          parity_bad;
    logic          emit;
    logic [9:0]    emit_data;

    // shreg holds {stop, parity, data[7:0]} once all ten bits are in
`ifdef PS2_PARITY_CHECK_EN
    assign parity_bad = ~(^shreg_q[8:0]);
`else
    assign parity_bad = 1'b0;
`endif

    // Frame reception, error classification and prefix accumulation
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        shreg_d      = shreg_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        emit         = 1'b0;
        emit_data    = {ext_pend_q, brk_pend_q, shreg_q[7:0]};
        case (state_q)
            S_IDLE: begin
                if (fall_q && !ps2d_sync_q) begin
                    state_d   = S_RX;
                    bit_cnt_d = 4'd10;
                    timer_d   = '0;
                end
            end
            S_RX: begin
                if (fall_q) begin
                    shreg_d   = {ps2d_sync_q, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    timer_d   = '0;
                    if (bit_cnt_q == 4'd1) begin
                        state_d = S_CHECK;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!shreg_q[9]) begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else if (parity_bad) begin
                    parity_err_d = 1'b1;
                    ext_pend_d   = 1'b0;
                    brk_pend_d   = 1'b0;
                end else if (shreg_q[7:0] == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (shreg_q[7:0] == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    emit       = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, frame shift register, prefix flags and registered error pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            timer_q      <= '0;
            shreg_q      <= 10'd0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            shreg_q      <= shreg_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push, drop;

    // A full FIFO still accepts a push when the head is popped in the same cycle
    always_comb begin
        full = (count_q == CW'(FIFO_DEPTH));
        pop  = (count_q != '0) & ev_ready;
        push = emit & (~full | pop);
        drop = emit & full & ~pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = emit_data;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = drop | (overflow_q & ~clear_ovf);
    end

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_valid   = (count_q != '0);
    assign ev_data    = mem_q[rd_ptr_q];
    assign ev_count   = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule
